// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor: passive HD44780 bus decoder keeping a 2x16 character shadow.
// Events are taken on the synchronized falling edge of lcd_en and applied one cycle later.
module lcd_bus_monitor #(
    parameter int CLK_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic        lcd_en,
    input  logic [7:0]  lcd_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char,
    output logic        disp_on,
    output logic [6:0]  cur_addr,
    output logic        busy,
    output logic        ovf,
    output logic        bad_addr,
    output logic [15:0] wr_cnt
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t state;
    logic [CLK_SYNC_STAGES-1:0][10:0] sync;
    logic [10:0] prev;
    logic [9:0]  evd;
    logic        ev, inc, act, we;
    logic [4:0]  idx, wa;
    logic [7:0]  wd;
    logic [6:0]  nxt;
    logic [7:0]  mem [32];
    // bit layout of every bus sample: {rs, rw, en, data}
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= '0;
            evd  <= '0;
            ev   <= 1'b0;
        end else begin
            sync <= {sync[CLK_SYNC_STAGES-2:0], {lcd_rs, lcd_rw, lcd_en, lcd_data}};
            prev <= sync[CLK_SYNC_STAGES-1];
            ev   <= prev[8] & ~sync[CLK_SYNC_STAGES-1][8];
            evd  <= {prev[10:9], prev[7:0]};
        end
    end
    assign busy = state == CLEAR;
    assign act  = ev & ~evd[8];
    always_comb begin
        nxt = inc ? (cur_addr == 7'h27 ? 7'h40 : cur_addr == 7'h67 ? 7'h00 : cur_addr + 7'd1)
                  : (cur_addr == 7'h00 ? 7'h67 : cur_addr == 7'h40 ? 7'h27 : cur_addr - 7'd1);
        we  = busy | (act & evd[9] & cur_addr[5:4] == 2'b00);
        wa  = busy ? idx : {cur_addr[6], cur_addr[3:0]};
        wd  = busy ? 8'h20 : evd[7:0];
    end
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            idx      <= '0;
            cur_addr <= '0;
            inc      <= 1'b1;
            disp_on  <= 1'b0;
            ovf      <= 1'b0;
            bad_addr <= 1'b0;
            wr_cnt   <= '0;
            rd_char  <= '0;
        end else begin
            rd_char <= mem[rd_addr];
            if (busy) begin
                idx <= idx + 5'd1;
                if (idx == 5'd31) state <= IDLE;
                if (act) ovf <= 1'b1;
            end else if (act && evd[9]) begin
                wr_cnt   <= wr_cnt + 16'd1;
                cur_addr <= nxt;
            end else if (act) begin
                casez (evd[7:0])
                    8'b1???????: begin
                        // legal windows are 0x00-0x27 and 0x40-0x67, i.e. low six bits <= 0x27
                        if (evd[5:0] <= 6'h27) cur_addr <= evd[6:0];
                        else bad_addr <= 1'b1;
                    end
                    8'b00001???: disp_on <= evd[2];
                    8'b000001??: inc <= evd[1];
                    8'b0000001?: cur_addr <= '0;
                    8'b00000001: begin
                        state    <= CLEAR;
                        idx      <= '0;
                        cur_addr <= '0;
                        inc      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_bus_monitor.sv
// tb_lcd_bus_monitor: directed bus transactions with hand-computed shadow/register expectations.
module tb_lcd_bus_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_en = 1'b0;
    logic [7:0]  lcd_data = '0;
    logic [4:0]  rd_addr = '0;
    logic [7:0]  rd_char;
    logic        disp_on, busy, ovf, bad_addr;
    logic [6:0]  cur_addr;
    logic [15:0] wr_cnt;
    int vectors = 0;
    int errors = 0;

    lcd_bus_monitor #(.CLK_SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
        .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .disp_on(disp_on),
        .cur_addr(cur_addr), .busy(busy), .ovf(ovf), .bad_addr(bad_addr), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic rs, input logic rw, input logic [7:0] d, input int gap);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check($sformatf("rd_char[%0d]", a), {8'h0, rd_char}, {8'h0, exp});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst cur_addr", {9'h0, cur_addr}, 16'h0);
        check("rst disp_on", {15'h0, disp_on}, 16'h0);
        check("rst ovf", {15'h0, ovf}, 16'h0);
        check("rst bad_addr", {15'h0, bad_addr}, 16'h0);
        check("rst wr_cnt", wr_cnt, 16'h0);
        check("rst rd_char", {8'h0, rd_char}, 16'h0);
        rst = 1'b0;
        repeat (31) @(posedge clk);
        #1 check("busy 31 after release", {15'h0, busy}, 16'h1);
        @(posedge clk);
        #1 check("busy 32 after release", {15'h0, busy}, 16'h0);
        for (int i = 0; i < 32; i++) rd(i[4:0], 8'h20);
        check("disp_on after init", {15'h0, disp_on}, 16'h0);

        bus(0, 0, 8'h0C, 6);
        bus(1, 0, 8'h41, 6);
        bus(1, 0, 8'h42, 6);
        check("disp_on 0x0C", {15'h0, disp_on}, 16'h1);
        rd(5'd0, 8'h41);
        rd(5'd1, 8'h42);
        check("cur_addr AB", {9'h0, cur_addr}, 16'h02);
        check("wr_cnt AB", wr_cnt, 16'd2);

        bus(0, 0, 8'hCF, 6);
        check("cur_addr 0xCF", {9'h0, cur_addr}, 16'h4F);
        bus(1, 0, 8'h5A, 6);
        check("cur_addr after Z", {9'h0, cur_addr}, 16'h50);
        bus(1, 0, 8'h59, 6);
        check("cur_addr after Y", {9'h0, cur_addr}, 16'h51);
        check("wr_cnt ZY", wr_cnt, 16'd4);
        rd(5'd31, 8'h5A);
        rd(5'd16, 8'h20);

        bus(0, 0, 8'h04, 6);
        bus(0, 0, 8'h80, 6);
        bus(1, 0, 8'h51, 6);
        rd(5'd0, 8'h51);
        check("dec wrap 00->67", {9'h0, cur_addr}, 16'h67);
        bus(0, 0, 8'hC0, 6);
        bus(1, 0, 8'h53, 6);
        rd(5'd16, 8'h53);
        check("dec wrap 40->27", {9'h0, cur_addr}, 16'h27);
        bus(0, 0, 8'h06, 6);
        bus(1, 0, 8'h54, 6);
        check("inc wrap 27->40", {9'h0, cur_addr}, 16'h40);
        bus(0, 0, 8'h02, 6);
        check("return home", {9'h0, cur_addr}, 16'h00);
        bus(0, 0, 8'hE7, 6);
        check("set addr 0x67", {9'h0, cur_addr}, 16'h67);
        bus(1, 0, 8'h52, 6);
        check("inc wrap 67->00", {9'h0, cur_addr}, 16'h00);
        check("wr_cnt wraps", wr_cnt, 16'd8);

        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data = 8'h01; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("busy before N+3", {15'h0, busy}, 16'h0);
        @(posedge clk);
        #1 check("busy at N+3", {15'h0, busy}, 16'h1);
        bus(1, 0, 8'h58, 6);
        check("busy during clear", {15'h0, busy}, 16'h1);
        repeat (40) @(negedge clk);
        check("busy after clear", {15'h0, busy}, 16'h0);
        check("ovf on drop", {15'h0, ovf}, 16'h1);
        check("cur_addr clear", {9'h0, cur_addr}, 16'h0);
        check("wr_cnt drop", wr_cnt, 16'd8);
        for (int i = 0; i < 32; i++) rd(i[4:0], 8'h20);

        bus(0, 0, 8'hA8, 6);
        check("bad_addr 0x28", {15'h0, bad_addr}, 16'h1);
        check("cur_addr kept", {9'h0, cur_addr}, 16'h0);
        bus(1, 1, 8'h55, 6);
        check("read ev wr_cnt", wr_cnt, 16'd8);
        check("read ev cur_addr", {9'h0, cur_addr}, 16'h0);
        rd(5'd0, 8'h20);
        bus(1, 0, 8'h4B, 6);
        rd(5'd0, 8'h4B);
        check("clear sets inc", {9'h0, cur_addr}, 16'h01);
        check("wr_cnt final", wr_cnt, 16'd9);
        bus(0, 0, 8'h08, 6);
        check("disp_on off", {15'h0, disp_on}, 16'h0);
        check("ovf sticky", {15'h0, ovf}, 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
